reset_sequencer: RTL



---
 rtl/reset_sequencer_if.sv | 27 ++
 rtl/reset_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer and its environment: lock / software request in,
// ordered stage resets and status out.
interface reset_sequencer_if #(
   parameter int unsigned NUM_STAGES = 4
);
   logic                  locked_in;
   logic                  sw_reset_req;
   logic [NUM_STAGES-1:0] stage_reset;
   logic                  seq_done;
   logic                  lock_timeout;

   modport master (
      input  locked_in,
      input  sw_reset_req,
      output stage_reset,
      output seq_done,
      output lock_timeout
   );

   modport slave (
      output locked_in,
      output sw_reset_req,
      input  stage_reset,
      input  seq_done,
      input  lock_timeout
   );
endinterface

// File: rtl/reset_sequencer.sv
// Ordered reset release: waits for stable clock lock, then drops stage resets one by one.
// Optional lock watchdog enabled by defining RST_SEQ_WATCHDOG_EN.
module reset_sequencer #(
   parameter int unsigned NUM_STAGES  = 4,
   parameter int unsigned STAGE_DELAY = 16,
   parameter int unsigned LOCK_STABLE = 64,
   parameter int unsigned WD_TIMEOUT  = 4096
) (
   input logic               clk,
   input logic               async_reset_n,
   reset_sequencer_if.master bus
);

   localparam int unsigned SW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
   localparam int unsigned DW = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
   localparam int unsigned IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   localparam logic [SW-1:0] STABLE_MAX = SW'(LOCK_STABLE - 1);
   localparam logic [DW-1:0] DLY_MAX    = DW'(STAGE_DELAY - 1);
   localparam logic [IW-1:0] IDX_MAX    = IW'(NUM_STAGES - 1);

   typedef enum logic [1:0] {StWaitLock, StRelease, StDone} state_e;

   (* ASYNC_REG = "TRUE" *) logic [1:0] lock_sync_q;
   logic                  locked_s;
   logic                  locked_armed_q;
   logic                  abort;

   state_e                state_q, state_d;
   logic [SW-1:0]         stable_cnt_q, stable_cnt_d;
   logic [DW-1:0]         dly_cnt_q, dly_cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [NUM_STAGES-1:0] stage_reset_q, stage_reset_d;
   logic                  seq_done_q, seq_done_d;

   assign locked_s = lock_sync_q[1];
   assign abort    = ~locked_s | bus.sw_reset_req;

   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         lock_sync_q    <= '0;
         locked_armed_q <= 1'b0;
      end else begin
         lock_sync_q    <= {lock_sync_q[0], bus.locked_in};
         locked_armed_q <= locked_s;
      end
   end

   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         state_q       <= StWaitLock;
         stable_cnt_q  <= '0;
         dly_cnt_q     <= '0;
         idx_q         <= '0;
         stage_reset_q <= '1;
         seq_done_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         stable_cnt_q  <= stable_cnt_d;
         dly_cnt_q     <= dly_cnt_d;
         idx_q         <= idx_d;
         stage_reset_q <= stage_reset_d;
         seq_done_q    <= seq_done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      stable_cnt_d  = stable_cnt_q;
      dly_cnt_d     = dly_cnt_q;
      idx_d         = idx_q;
      stage_reset_d = stage_reset_q;
      seq_done_d    = seq_done_q;

      if (abort) begin
         state_d       = StWaitLock;
         stable_cnt_d  = '0;
         dly_cnt_d     = '0;
         idx_d         = '0;
         stage_reset_d = '1;
         seq_done_d    = 1'b0;
      end else begin
         unique case (state_q)
            StWaitLock: begin
               // The first high sample after a low only arms the count: 2+LOCK_STABLE latency.
               if (locked_armed_q) begin
                  if (stable_cnt_q == STABLE_MAX) begin
                     state_d      = StRelease;
                     stable_cnt_d = '0;
                     dly_cnt_d    = '0;
                     idx_d        = '0;
                  end else begin
                     stable_cnt_d = stable_cnt_q + SW'(1);
                  end
               end
            end
            StRelease: begin
               if (dly_cnt_q == DLY_MAX) begin
                  stage_reset_d[idx_q] = 1'b0;
                  dly_cnt_d            = '0;
                  if (idx_q == IDX_MAX) begin
                     state_d    = StDone;
                     seq_done_d = 1'b1;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end else begin
                  dly_cnt_d = dly_cnt_q + DW'(1);
               end
            end
            StDone: begin
            end
            default: state_d = StWaitLock;
         endcase
      end
   end

   assign bus.stage_reset = stage_reset_q;
   assign bus.seq_done    = seq_done_q;

`ifdef RST_SEQ_WATCHDOG_EN
   localparam int unsigned WW = $clog2(WD_TIMEOUT);
   localparam logic [WW-1:0] WD_MAX = WW'(WD_TIMEOUT - 1);

   logic [WW-1:0] wd_cnt_q, wd_cnt_d;
   logic          lock_timeout_q, lock_timeout_d;

   always_comb begin
      wd_cnt_d       = '0;
      lock_timeout_d = lock_timeout_q;
      if (state_q == StWaitLock) begin
         if (wd_cnt_q == WD_MAX) begin
            lock_timeout_d = 1'b1;
         end else begin
            wd_cnt_d = wd_cnt_q + WW'(1);
         end
      end
      if (seq_done_d && !seq_done_q) begin
         lock_timeout_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         wd_cnt_q       <= '0;
         lock_timeout_q <= 1'b0;
      end else begin
         wd_cnt_q       <= wd_cnt_d;
         lock_timeout_q <= lock_timeout_d;
      end
   end

   assign bus.lock_timeout = lock_timeout_q;
`else
   assign bus.lock_timeout = 1'b0;
`endif

endmodule
